// File: rtl/coolgirl_config_regs_if.sv
// CPU bus seen by the CoolGirl configuration register bank.
// The master drives the bus; the register bank observes it as a slave.
interface coolgirl_config_regs_if;
    logic        romsel;
    logic        cpu_rw_in;
    logic [14:0] cpu_addr_in;
    logic [7:0]  cpu_data_in;

    modport master (
        output romsel,
        output cpu_rw_in,
        output cpu_addr_in,
        output cpu_data_in
    );

    modport slave (
        input romsel,
        input cpu_rw_in,
        input cpu_addr_in,
        input cpu_data_in
    );
endinterface

// File: rtl/coolgirl_config_regs.sv
// CoolGirl configuration register bank and lock sequencer.
// The menu writes shadow registers at $5000-$5FFF (8 registers, mirrored
// every 8 bytes). An R7 write with COMMIT or LOCK copies every shadow to the
// live outputs in one edge; LOCK also freezes the block until reset.
// All state updates on the falling edge of m2.
module coolgirl_config_regs #(
    parameter logic [12:0] CPU_BASE_RESET = 13'h0000,
    parameter bit          LOCK_ON_RESET  = 1'b0
) (
    input  logic                         m2,
    input  logic                         reset,
    coolgirl_config_regs_if.slave        bus,
    output logic [12:0]                  cpu_base,
    output logic [4:0]                   cpu_mask,
    output logic [4:0]                   chr_mask,
    output logic [4:0]                   mapper,
    output logic [2:0]                   flags,
    output logic [1:0]                   mirroring,
    output logic                         sram_enabled,
    output logic [1:0]                   sram_page,
    output logic                         prg_write_enabled,
    output logic                         chr_write_enabled,
    output logic                         map_rom_on_6000,
    output logic                         commit_pulse,
    output logic                         lockout
);

    typedef enum logic {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } state_t;

    typedef struct packed {
        logic [12:0] cpu_base;
        logic [4:0]  cpu_mask;
        logic [4:0]  chr_mask;
        logic [4:0]  mapper;
        logic [2:0]  flags;
        logic [1:0]  mirroring;
        logic        sram_enabled;
        logic [1:0]  sram_page;
        logic        prg_write_enabled;
        logic        chr_write_enabled;
        logic        map_rom_on_6000;
    } cfg_t;

    localparam cfg_t   CFG_RESET   = '{CPU_BASE_RESET, 5'd0, 5'd0, 5'd0, 3'd0,
                                       2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0};
    localparam state_t STATE_RESET = LOCK_ON_RESET ? ST_LOCKED : ST_UNLOCKED;

    state_t state_q, state_d;
    cfg_t   shadow_q, shadow_d;
    cfg_t   live_q, live_d;
    logic   commit_pulse_q, commit_pulse_d;

    logic       cfg_wr_s;
    logic [2:0] reg_idx_s;
    logic       commit_s;
    logic       lock_s;

    // Address bits 11..3 only select a mirror of the 8 registers.
    logic unused_addr_s;
    assign unused_addr_s = ^bus.cpu_addr_in[11:3];

    // Decode a valid write and work out next shadow, live and pulse values.
    always_comb begin
        cfg_wr_s  = ~bus.cpu_rw_in & bus.romsel & bus.cpu_addr_in[14] &
                    ~bus.cpu_addr_in[13] & bus.cpu_addr_in[12] &
                    (state_q == ST_UNLOCKED);
        reg_idx_s = bus.cpu_addr_in[2:0];
        commit_s  = cfg_wr_s & (reg_idx_s == 3'd7) &
                    (bus.cpu_data_in[0] | bus.cpu_data_in[7]);
        lock_s    = cfg_wr_s & (reg_idx_s == 3'd7) & bus.cpu_data_in[7];
        shadow_d  = shadow_q;
        if (cfg_wr_s) begin
            case (reg_idx_s)
                3'd0: shadow_d.cpu_base[12:8] = bus.cpu_data_in[4:0];
                3'd1: shadow_d.cpu_base[7:0]  = bus.cpu_data_in[7:0];
                3'd2: shadow_d.cpu_mask       = bus.cpu_data_in[4:0];
                3'd3: shadow_d.chr_mask       = bus.cpu_data_in[4:0];
                3'd4: shadow_d.mapper         = bus.cpu_data_in[4:0];
                3'd5: begin
                    shadow_d.flags        = bus.cpu_data_in[2:0];
                    shadow_d.mirroring    = bus.cpu_data_in[4:3];
                    shadow_d.sram_enabled = bus.cpu_data_in[5];
                    shadow_d.sram_page    = bus.cpu_data_in[7:6];
                end
                3'd6: begin
                    shadow_d.prg_write_enabled = bus.cpu_data_in[0];
                    shadow_d.chr_write_enabled = bus.cpu_data_in[1];
                    shadow_d.map_rom_on_6000   = bus.cpu_data_in[2];
                end
                default: shadow_d = shadow_q;
            endcase
        end else begin
            shadow_d = shadow_q;
        end
        if (commit_s) begin
            live_d = shadow_q;
        end else begin
            live_d = live_q;
        end
        commit_pulse_d = commit_s;
    end

    // Lock state: only a LOCK write leaves UNLOCKED, only reset leaves LOCKED.
    always_comb begin
        case (state_q)
            ST_UNLOCKED: state_d = lock_s ? ST_LOCKED : ST_UNLOCKED;
            ST_LOCKED:   state_d = ST_LOCKED;
            default:     state_d = ST_LOCKED;
        endcase
    end

    // State registers, updated on the falling edge of m2.
    always_ff @(negedge m2 or posedge reset) begin
        if (reset) begin
            state_q        <= STATE_RESET;
            shadow_q       <= CFG_RESET;
            live_q         <= CFG_RESET;
            commit_pulse_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            shadow_q       <= shadow_d;
            live_q         <= live_d;
            commit_pulse_q <= commit_pulse_d;
        end
    end

    assign cpu_base          = live_q.cpu_base;
    assign cpu_mask          = live_q.cpu_mask;
    assign chr_mask          = live_q.chr_mask;
    assign mapper            = live_q.mapper;
    assign flags             = live_q.flags;
    assign mirroring         = live_q.mirroring;
    assign sram_enabled      = live_q.sram_enabled;
    assign sram_page         = live_q.sram_page;
    assign prg_write_enabled = live_q.prg_write_enabled;
    assign chr_write_enabled = live_q.chr_write_enabled;
    assign map_rom_on_6000   = live_q.map_rom_on_6000;
    assign commit_pulse      = commit_pulse_q;
    assign lockout           = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_coolgirl_config_regs.sv
// Directed, table-driven bench for coolgirl_config_regs.
module tb_coolgirl_config_regs;

    logic m2;
    logic reset;
    coolgirl_config_regs_if bus ();

    // Outputs of the default instance.
    logic [12:0] a_base;
    logic [4:0]  a_pmask, a_cmask, a_mapper;
    logic [2:0]  a_flags;
    logic [1:0]  a_mirr, a_page;
    logic        a_sen, a_pwe, a_cwe, a_rom6, a_cp, a_lk;
    // Outputs of the lock-on-reset instance.
    logic [12:0] b_base;
    logic [4:0]  b_pmask, b_cmask, b_mapper;
    logic [2:0]  b_flags;
    logic [1:0]  b_mirr, b_page;
    logic        b_sen, b_pwe, b_cwe, b_rom6, b_cp, b_lk;

    coolgirl_config_regs dut_a (
        .m2(m2), .reset(reset), .bus(bus),
        .cpu_base(a_base), .cpu_mask(a_pmask), .chr_mask(a_cmask),
        .mapper(a_mapper), .flags(a_flags), .mirroring(a_mirr),
        .sram_enabled(a_sen), .sram_page(a_page),
        .prg_write_enabled(a_pwe), .chr_write_enabled(a_cwe),
        .map_rom_on_6000(a_rom6), .commit_pulse(a_cp), .lockout(a_lk)
    );

    coolgirl_config_regs #(.CPU_BASE_RESET(13'h0040), .LOCK_ON_RESET(1'b1)) dut_b (
        .m2(m2), .reset(reset), .bus(bus),
        .cpu_base(b_base), .cpu_mask(b_pmask), .chr_mask(b_cmask),
        .mapper(b_mapper), .flags(b_flags), .mirroring(b_mirr),
        .sram_enabled(b_sen), .sram_page(b_page),
        .prg_write_enabled(b_pwe), .chr_write_enabled(b_cwe),
        .map_rom_on_6000(b_rom6), .commit_pulse(b_cp), .lockout(b_lk)
    );

    // Observed outputs packed as {base, pmask, cmask, mapper, R5 layout, R6 layout, cp, lock}.
    logic [40:0] obs_a, obs_b;
    assign obs_a = {a_base, a_pmask, a_cmask, a_mapper, a_page, a_sen, a_mirr, a_flags,
                    a_rom6, a_cwe, a_pwe, a_cp, a_lk};
    assign obs_b = {b_base, b_pmask, b_cmask, b_mapper, b_page, b_sen, b_mirr, b_flags,
                    b_rom6, b_cwe, b_pwe, b_cp, b_lk};

    typedef struct {
        logic [14:0] addr;
        logic [7:0]  data;
        logic        rw;
        logic        romsel;
        logic [12:0] base;
        logic [4:0]  pmask;
        logic [4:0]  cmask;
        logic [4:0]  mapper;
        logic [7:0]  r5;
        logic [2:0]  r6;
        logic        cp;
        logic        lk;
    } vec_t;

    vec_t tbl [19];
    int   n_vec = 0;
    int   n_bad = 0;

    initial m2 = 1'b1;
    always #10 m2 = ~m2;

    function automatic logic [40:0] pack_exp(input logic [12:0] base, input logic [4:0] pmask,
                                             input logic [4:0] cmask, input logic [4:0] mapper,
                                             input logic [7:0] r5, input logic [2:0] r6,
                                             input logic cp, input logic lk);
        return {base, pmask, cmask, mapper, r5, r6, cp, lk};
    endfunction

    task automatic check(input string name, input logic [40:0] act, input logic [40:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One bus cycle sampled at a falling m2 edge; returns 1 time unit after that edge.
    task automatic bus_cycle(input logic [14:0] addr, input logic [7:0] data,
                             input logic rw, input logic rs);
        @(posedge m2);
        #1;
        bus.cpu_addr_in = addr;
        bus.cpu_data_in = data;
        bus.cpu_rw_in   = rw;
        bus.romsel      = rs;
        @(negedge m2);
        #1;
        bus.cpu_rw_in   = 1'b1;
    endtask

    initial begin
        //            addr      data   rw    rs    base      pm     cm     map    r5     r6    cp    lk
        tbl[0]  = '{15'h5001, 8'h3C, 1'b0, 1'b1, 13'h0000, 5'h00, 5'h00, 5'h00, 8'h00, 3'd0, 1'b0, 1'b0};
        tbl[1]  = '{15'h5004, 8'h11, 1'b0, 1'b1, 13'h0000, 5'h00, 5'h00, 5'h00, 8'h00, 3'd0, 1'b0, 1'b0};
        tbl[2]  = '{15'h5000, 8'h1F, 1'b0, 1'b1, 13'h0000, 5'h00, 5'h00, 5'h00, 8'h00, 3'd0, 1'b0, 1'b0};
        tbl[3]  = '{15'h5001, 8'hFF, 1'b0, 1'b1, 13'h0000, 5'h00, 5'h00, 5'h00, 8'h00, 3'd0, 1'b0, 1'b0};
        tbl[4]  = '{15'h5005, 8'hA9, 1'b0, 1'b1, 13'h0000, 5'h00, 5'h00, 5'h00, 8'h00, 3'd0, 1'b0, 1'b0};
        tbl[5]  = '{15'h5007, 8'h01, 1'b0, 1'b1, 13'h1FFF, 5'h00, 5'h00, 5'h11, 8'hA9, 3'd0, 1'b1, 1'b0};
        tbl[6]  = '{15'h5002, 8'h1F, 1'b1, 1'b1, 13'h1FFF, 5'h00, 5'h00, 5'h11, 8'hA9, 3'd0, 1'b0, 1'b0};
        tbl[7]  = '{15'h5002, 8'h1F, 1'b0, 1'b0, 13'h1FFF, 5'h00, 5'h00, 5'h11, 8'hA9, 3'd0, 1'b0, 1'b0};
        tbl[8]  = '{15'h6002, 8'h1F, 1'b0, 1'b1, 13'h1FFF, 5'h00, 5'h00, 5'h11, 8'hA9, 3'd0, 1'b0, 1'b0};
        tbl[9]  = '{15'h5007, 8'h01, 1'b0, 1'b1, 13'h1FFF, 5'h00, 5'h00, 5'h11, 8'hA9, 3'd0, 1'b1, 1'b0};
        tbl[10] = '{15'h5007, 8'h00, 1'b0, 1'b1, 13'h1FFF, 5'h00, 5'h00, 5'h11, 8'hA9, 3'd0, 1'b0, 1'b0};
        tbl[11] = '{15'h5003, 8'h15, 1'b0, 1'b1, 13'h1FFF, 5'h00, 5'h00, 5'h11, 8'hA9, 3'd0, 1'b0, 1'b0};
        tbl[12] = '{15'h5006, 8'hFD, 1'b0, 1'b1, 13'h1FFF, 5'h00, 5'h00, 5'h11, 8'hA9, 3'd0, 1'b0, 1'b0};
        tbl[13] = '{15'h5002, 8'hE3, 1'b0, 1'b1, 13'h1FFF, 5'h00, 5'h00, 5'h11, 8'hA9, 3'd0, 1'b0, 1'b0};
        tbl[14] = '{15'h5FF4, 8'h07, 1'b0, 1'b1, 13'h1FFF, 5'h00, 5'h00, 5'h11, 8'hA9, 3'd0, 1'b0, 1'b0};
        tbl[15] = '{15'h5007, 8'h80, 1'b0, 1'b1, 13'h1FFF, 5'h03, 5'h15, 5'h07, 8'hA9, 3'd5, 1'b1, 1'b1};
        tbl[16] = '{15'h5004, 8'h02, 1'b0, 1'b1, 13'h1FFF, 5'h03, 5'h15, 5'h07, 8'hA9, 3'd5, 1'b0, 1'b1};
        tbl[17] = '{15'h5007, 8'h01, 1'b0, 1'b1, 13'h1FFF, 5'h03, 5'h15, 5'h07, 8'hA9, 3'd5, 1'b0, 1'b1};
        tbl[18] = '{15'h5000, 8'h00, 1'b0, 1'b1, 13'h1FFF, 5'h03, 5'h15, 5'h07, 8'hA9, 3'd5, 1'b0, 1'b1};

        bus.romsel      = 1'b1;
        bus.cpu_rw_in   = 1'b1;
        bus.cpu_addr_in = 15'h0000;
        bus.cpu_data_in = 8'h00;
        reset           = 1'b1;
        #25;
        check("reset_a", obs_a, pack_exp(13'h0000, 5'h00, 5'h00, 5'h00, 8'h00, 3'd0, 1'b0, 1'b0));
        check("reset_b", obs_b, pack_exp(13'h0040, 5'h00, 5'h00, 5'h00, 8'h00, 3'd0, 1'b0, 1'b1));
        @(posedge m2);
        #2;
        reset = 1'b0;

        for (int i = 0; i < 19; i++) begin
            bus_cycle(tbl[i].addr, tbl[i].data, tbl[i].rw, tbl[i].romsel);
            check($sformatf("vec%0d", i), obs_a,
                  pack_exp(tbl[i].base, tbl[i].pmask, tbl[i].cmask, tbl[i].mapper,
                           tbl[i].r5, tbl[i].r6, tbl[i].cp, tbl[i].lk));
        end

        // Asynchronous reset while locked clears everything between edges.
        #3;
        reset = 1'b1;
        #1;
        check("async_reset_a", obs_a, pack_exp(13'h0000, 5'h00, 5'h00, 5'h00, 8'h00, 3'd0, 1'b0, 1'b0));
        @(posedge m2);
        #2;
        reset = 1'b0;

        // Uncommitted shadow data is lost on reset.
        bus_cycle(15'h5006, 8'h07, 1'b0, 1'b1);
        check("r6_uncommitted", obs_a, pack_exp(13'h0000, 5'h00, 5'h00, 5'h00, 8'h00, 3'd0, 1'b0, 1'b0));
        #3;
        reset = 1'b1;
        #1;
        check("reset_mid_seq", obs_a, pack_exp(13'h0000, 5'h00, 5'h00, 5'h00, 8'h00, 3'd0, 1'b0, 1'b0));
        @(posedge m2);
        #2;
        reset = 1'b0;
        bus_cycle(15'h5007, 8'h01, 1'b0, 1'b1);
        check("commit_after_reset", obs_a, pack_exp(13'h0000, 5'h00, 5'h00, 5'h00, 8'h00, 3'd0, 1'b1, 1'b0));

        // Two back-to-back commits keep the pulse high for two cycles.
        bus_cycle(15'h5007, 8'h01, 1'b0, 1'b1);
        check("commit_second", obs_a, pack_exp(13'h0000, 5'h00, 5'h00, 5'h00, 8'h00, 3'd0, 1'b1, 1'b0));
        bus_cycle(15'h5007, 8'h01, 1'b1, 1'b1);
        check("pulse_drop", obs_a, pack_exp(13'h0000, 5'h00, 5'h00, 5'h00, 8'h00, 3'd0, 1'b0, 1'b0));

        // Lock-on-reset instance ignores R1 write and a commit+lock.
        bus_cycle(15'h5001, 8'h55, 1'b0, 1'b1);
        bus_cycle(15'h5007, 8'h81, 1'b0, 1'b1);
        check("locked_b_pulse", obs_b, pack_exp(13'h0040, 5'h00, 5'h00, 5'h00, 8'h00, 3'd0, 1'b0, 1'b1));
        bus_cycle(15'h5007, 8'h81, 1'b1, 1'b1);
        check("locked_b_hold", obs_b, pack_exp(13'h0040, 5'h00, 5'h00, 5'h00, 8'h00, 3'd0, 1'b0, 1'b1));
        // The default instance committed R1=$55 and locked on the same writes.
        check("lock_a_after_81", obs_a, pack_exp(13'h0055, 5'h00, 5'h00, 5'h00, 8'h00, 3'd0, 1'b0, 1'b1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
